// File: rtl/ecc_pkg.sv
// Shared types for the ECC operation scheduler: operation, code mode,
// response status and scheduler state encodings.
package ecc_pkg;

  typedef enum logic [1:0] {OP_ENC, OP_DEC, OP_FULL, OP_RSV} op_e;
  typedef enum logic [1:0] {MODE_H1, MODE_H2, MODE_H3, MODE_ILL} mode_e;
  typedef enum logic [1:0] {ST_OK, ST_CORR, ST_DET, ST_ERR} status_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  // Decoder error count to response status; a count of 3 is not a legal
  // decoder answer and is reported as an error.
  function automatic status_e err_to_status(input logic [1:0] num_err);
    status_e st;
    case (num_err)
      2'd0:    st = ST_OK;
      2'd1:    st = ST_CORR;
      2'd2:    st = ST_DET;
      default: st = ST_ERR;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/ecc_op_sched_if.sv
// Bundle of the requester, datapath and response signals of the scheduler.
// slave  : the scheduler's view.
// master : the surrounding system (requesters, datapath, response sink).
//
// Handshakes: a request is taken on a clock edge where req_valid[i] and
// req_ready[i] are both high; a response is taken on an edge where
// rsp_valid and rsp_ready are both high, and rsp_* hold steady until then.
// dp_start is a one-cycle launch, dp_done a one-cycle completion, and dp_*
// operands hold steady from dp_start until dp_done.
interface ecc_op_sched_if #(parameter int DATA_WIDTH = 32);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][1:0]            req_op;
  logic [1:0][1:0]            req_mode;
  logic [1:0][DATA_WIDTH-1:0] req_data;
  logic                       dp_start;
  logic                       dp_op;
  logic [1:0]                 dp_mode;
  logic [DATA_WIDTH-1:0]      dp_data;
  logic                       dp_done;
  logic [DATA_WIDTH-1:0]      dp_result;
  logic [1:0]                 dp_num_err;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_id;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic [1:0]                 rsp_status;

  modport slave (
    input  req_valid, req_op, req_mode, req_data,
    input  dp_done, dp_result, dp_num_err, rsp_ready,
    output req_ready, dp_start, dp_op, dp_mode, dp_data,
    output rsp_valid, rsp_id, rsp_data, rsp_status
  );

  modport master (
    output req_valid, req_op, req_mode, req_data,
    output dp_done, dp_result, dp_num_err, rsp_ready,
    input  req_ready, dp_start, dp_op, dp_mode, dp_data,
    input  rsp_valid, rsp_id, rsp_data, rsp_status
  );
endinterface

// File: rtl/ecc_rr_arb2.sv
// Two-way round-robin arbiter. The pointer side wins a tie; after a grant
// is used the pointer moves to the requester that did not win.
module ecc_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr;

  // Pick the single requester, or the pointer side when both ask.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Point at the loser of the grant just used (grant[0] set means 0 won).
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/ecc_op_sched.sv
// Scheduler for the shared Hamming ECC datapath: arbitrates two requesters,
// runs one datapath pass at a time (two for FULL_CHANNEL: encode then
// decode), guards each pass with a watchdog and returns a status code.
module ecc_op_sched
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 5
) (
  input  logic           clk,
  input  logic           rst,
  ecc_op_sched_if.slave  bus,
  output state_e         state
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]            grant;
  logic                  winner;
  logic                  accept;
  logic [1:0]            sel_op;
  logic [1:0]            sel_mode;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_illegal;
  logic                  is_full;
  logic [CNT_W-1:0]      wdog;

  ecc_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .update (accept),
    .grant  (grant)
  );

  assign winner        = grant[1];
  assign accept        = (state == S_IDLE) && (grant != 2'b00);
  assign bus.req_ready = (state == S_IDLE) ? grant : 2'b00;
  assign sel_op        = bus.req_op[winner];
  assign sel_mode      = bus.req_mode[winner];
  assign sel_data      = bus.req_data[winner];
  assign sel_illegal   = (sel_op == OP_RSV) || (sel_mode == MODE_ILL);

  // Sequencer: accept, launch pass(es), watch for completion, hand back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      is_full        <= 1'b0;
      wdog           <= '0;
      bus.dp_start   <= 1'b0;
      bus.dp_op      <= 1'b0;
      bus.dp_mode    <= 2'b00;
      bus.dp_data    <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_status <= ST_OK;
    end else begin
      bus.dp_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            bus.rsp_id <= winner;
            is_full    <= (sel_op == OP_FULL);
            if (sel_illegal) begin
              bus.rsp_data   <= sel_data;
              bus.rsp_status <= ST_ERR;
              bus.rsp_valid  <= 1'b1;
              state          <= S_RESP;
            end else begin
              bus.dp_start <= 1'b1;
              bus.dp_op    <= (sel_op == OP_DEC);
              bus.dp_mode  <= sel_mode;
              bus.dp_data  <= sel_data;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog + 1'b1;
          if (bus.dp_done) begin
            if (is_full && !bus.dp_op) begin
              // Feed the fresh codeword straight back for the decode pass.
              bus.dp_data  <= bus.dp_result;
              bus.dp_op    <= 1'b1;
              bus.dp_start <= 1'b1;
              state        <= S_ISSUE;
            end else begin
              bus.rsp_data   <= bus.dp_result;
              bus.rsp_status <= bus.dp_op ? err_to_status(bus.dp_num_err) : ST_OK;
              bus.rsp_valid  <= 1'b1;
              state          <= S_RESP;
            end
          end else if (wdog == WD_LAST) begin
            bus.rsp_data   <= '0;
            bus.rsp_status <= ST_ERR;
            bus.rsp_valid  <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_op_sched.sv
// Bench for ecc_op_sched: the bench plays both requesters, the datapath and
// the response sink; expected responses come from a transaction-level model.
module tb_ecc_op_sched;
  import ecc_pkg::*;

  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic   clk;
  logic   rst;
  state_e state;

  ecc_op_sched_if #(.DATA_WIDTH(DW)) bus ();

  ecc_op_sched #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [34:0] exp_q[$];   // {id, status, data}
  bit m_ptr;               // model round-robin pointer

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected response from the operation rules alone.
  function automatic logic [34:0] model_rsp(input bit id, input logic [1:0] op,
      input logic [1:0] mode, input logic [31:0] data, input int lat,
      input logic [31:0] enc_res, input logic [31:0] dec_res, input logic [1:0] nerr);
    if (op == 2'd3 || mode == 2'd3) return {id, 2'd3, data};
    if (lat == 0 || lat > TIMEOUT)  return {id, 2'd3, 32'd0};
    if (op == 2'd0)                 return {id, 2'd0, enc_res};
    return {id, nerr, dec_res};
  endfunction

  // Cycles from the accept cycle to the first cycle with rsp_valid.
  function automatic int model_lat(input logic [1:0] op, input logic [1:0] mode, input int lat);
    if (op == 2'd3 || mode == 2'd3) return 1;
    if (lat == 0 || lat > TIMEOUT)  return 2 + TIMEOUT;
    if (op == 2'd2)                 return 3 + 2 * lat;
    return 2 + lat;
  endfunction

  function automatic int model_starts(input logic [1:0] op, input logic [1:0] mode, input int lat);
    if (op == 2'd3 || mode == 2'd3) return 0;
    if (op == 2'd2 && lat != 0 && lat <= TIMEOUT) return 2;
    return 1;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_dp"}, {bus.req_ready, bus.dp_start, bus.dp_op, bus.dp_mode, bus.dp_data}, '0);
    chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_status, bus.rsp_data}, '0);
    chk({tag, "_state"}, 64'(state), 64'(S_IDLE));
  endtask

  // ---------------- driver: one full transaction ----------------
  // Called at a negedge with the DUT idle. lat = dp_start-to-dp_done cycles
  // for every pass (0 = the datapath never answers).
  task automatic txn(input string tag, input logic [1:0] vmask,
      input logic [1:0] op0, input logic [1:0] mode0, input logic [31:0] d0,
      input logic [1:0] op1, input logic [1:0] mode1, input logic [31:0] d1,
      input int lat, input logic [31:0] enc_res, input logic [31:0] dec_res,
      input logic [1:0] nerr, input int rsp_wait);
    bit w, got_rsp, exp_dp_op;
    logic [1:0] wop, wmode;
    logic [31:0] wd, exp_dp_data;
    logic [34:0] e;
    int cyc, done_at, starts, exp_lat, exp_starts;

    w     = (vmask == 2'b11) ? m_ptr : vmask[1];
    wop   = w ? op1 : op0;
    wmode = w ? mode1 : mode0;
    wd    = w ? d1 : d0;
    exp_q.push_back(model_rsp(w, wop, wmode, wd, lat, enc_res, dec_res, nerr));
    exp_lat    = model_lat(wop, wmode, lat);
    exp_starts = model_starts(wop, wmode, lat);

    bus.req_valid = vmask;
    bus.req_op    = {op1, op0};
    bus.req_mode  = {mode1, mode0};
    bus.req_data  = {d1, d0};
    bus.rsp_ready = (rsp_wait == 0);
    #1;
    chk({tag, "_req_ready"}, bus.req_ready, 2'b01 << w);
    @(posedge clk);
    m_ptr = ~w;
    @(negedge clk);
    bus.req_valid = 2'b00;

    exp_dp_op   = (wop == 2'd1);
    exp_dp_data = wd;
    done_at = -1; starts = 0; got_rsp = 0; cyc = 1;
    while (!got_rsp && cyc <= 100) begin
      bus.dp_done = 1'b0;
      if (bus.dp_start) begin
        starts++;
        chk({tag, "_dp_op"}, bus.dp_op, exp_dp_op);
        chk({tag, "_dp_mode"}, bus.dp_mode, wmode);
        chk({tag, "_dp_data"}, bus.dp_data, exp_dp_data);
        if (lat > 0) done_at = cyc + lat;
      end
      if (cyc == done_at) begin
        bus.dp_done    = 1'b1;
        bus.dp_result  = exp_dp_op ? dec_res : enc_res;
        bus.dp_num_err = nerr;
        if (!exp_dp_op) begin
          exp_dp_op   = 1'b1;
          exp_dp_data = enc_res;
        end
      end
      if (bus.rsp_valid) got_rsp = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end

    e = exp_q.pop_front();
    if (!got_rsp) begin
      chk({tag, "_rsp_seen"}, 0, 1);
      bus.rsp_ready = 1'b1;
      bus.dp_done   = 1'b0;
      return;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_rsp_id"}, bus.rsp_id, e[34]);
    chk({tag, "_rsp_status"}, bus.rsp_status, e[33:32]);
    chk({tag, "_rsp_data"}, bus.rsp_data, e[31:0]);
    chk({tag, "_dp_starts"}, starts, exp_starts);
    for (int i = 0; i < rsp_wait; i++) begin
      @(negedge clk);
      bus.dp_done = 1'b0;
      chk({tag, "_rsp_hold"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_status, bus.rsp_data}, {1'b1, e});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.dp_done   = 1'b0;
    chk({tag, "_rsp_drop"}, bus.rsp_valid, 1'b0);
    chk({tag, "_back_idle"}, 64'(state), 64'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_op     = '0;
    bus.req_mode   = '0;
    bus.req_data   = '0;
    bus.dp_done    = 1'b0;
    bus.dp_result  = '0;
    bus.dp_num_err = 2'd0;
    bus.rsp_ready  = 1'b0;
    m_ptr          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: encode H2 with a 1-cycle datapath, 3-cycle latency
    txn("enc_h2", 2'b01, 2'd0, 2'd1, 32'h0000_07FF, 2'd0, 2'd0, 32'h0,
        1, 32'h0000_FFFF, 32'h0, 2'd0, 0);

    // 2: both valid for four transactions -> grants alternate
    for (int i = 0; i < 4; i++)
      txn("rr_both", 2'b11, 2'd0, 2'd2, $urandom, 2'd1, 2'd0, $urandom,
          1, $urandom, $urandom, 2'(i % 3), i % 2);

    // 3: full channel from requester 1, corrected single error
    txn("full_h1", 2'b10, 2'd0, 2'd0, 32'h0, 2'd2, 2'd0, 32'h5,
        1, 32'h0000_0035, 32'h0000_0005, 2'd1, 0);

    // 4: decode with a silent datapath, then the dp_done boundary cases
    txn("dec_timeout", 2'b01, 2'd1, 2'd2, 32'h1234_5678, 2'd0, 2'd0, 32'h0,
        0, 32'h0, 32'hAAAA_AAAA, 2'd0, 0);
    bus.dp_done = 1'b1;
    @(negedge clk);
    bus.dp_done = 1'b0;
    chk("stray_done_rsp", bus.rsp_valid, 1'b0);
    chk("stray_done_start", bus.dp_start, 1'b0);
    chk("stray_done_state", 64'(state), 64'(S_IDLE));
    txn("dec_done_at_limit", 2'b01, 2'd1, 2'd2, 32'h0F0F_0F0F, 2'd0, 2'd0, 32'h0,
        TIMEOUT, 32'h0, 32'h0000_BEEF, 2'd2, 0);
    txn("dec_done_late", 2'b01, 2'd1, 2'd2, 32'h0F0F_0F0F, 2'd0, 2'd0, 32'h0,
        TIMEOUT + 1, 32'h0, 32'h0000_BEEF, 2'd2, 1);

    // 5: illegal mode bypasses the datapath
    txn("ill_mode", 2'b01, 2'd0, 2'd3, 32'hDEAD_BEEF, 2'd0, 2'd0, 32'h0,
        1, 32'h1, 32'h2, 2'd0, 1);

    // 6: reset during WAIT of a full-channel operation
    bus.req_valid = 2'b01;
    bus.req_op    = {2'd0, 2'd2};
    bus.req_mode  = {2'd0, 2'd1};
    bus.req_data  = {32'h0, 32'h0000_00A5};
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    chk("pre_reset_state", 64'(state), 64'(S_WAIT));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("mid_reset");
    rst   = 1'b1;
    m_ptr = 1'b0;
    bus.dp_done = 1'b1;
    @(negedge clk);
    bus.dp_done = 1'b0;
    chk("late_done_rsp", bus.rsp_valid, 1'b0);
    txn("after_reset_enc", 2'b11, 2'd0, 2'd0, 32'h0000_0011, 2'd0, 2'd1, 32'h0000_0022,
        2, 32'h0000_0077, 32'h0, 2'd0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int lat;
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      txn("rand", 2'($urandom_range(1, 3)),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
          lat, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
